// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war round controller.
package tug_pkg;

  // Round controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ARMED = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bits 7, 5, 4, 3 of a left-shifting register)
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Width of the signed rope position
  localparam int POS_W = 4;

  // One step of the Fibonacci LFSR: shift left, feed the tap parity into bit 0
  function automatic logic [7:0] lfsrNext(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/tug_lfsr.sv
// Free-running 8-bit Fibonacci LFSR; supplies the random part of the start delay.
import tug_pkg::*;

module tug_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] rnd_o
);

  logic [7:0] lfsr_q;

  // Advance every clock; reset reseeds so each power-on sequence repeats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsrNext(lfsr_q);
    end
  end

  // Only the low nibble feeds the delay
  assign rnd_o = lfsr_q[3:0];

endmodule

// File: rtl/tug_referee.sv
// Round controller: random start delay, push arbitration, false-start penalties and rope position.
import tug_pkg::*;

module tug_referee #(
  parameter int         DELAY_BASE = 16,
  parameter int         WIN_POS    = 4,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             start,
  input  logic             lpush,
  input  logic             rpush,
  output logic             go,
  output logic [POS_W-1:0] pos,
  output logic             lpoint,
  output logic             rpoint,
  output logic             foul,
  output logic             over,
  output logic             winner
);

  localparam logic [7:0]       DelayBase8 = 8'(DELAY_BASE);
  localparam logic [POS_W-1:0] WinPos     = POS_W'(WIN_POS);
  localparam logic [POS_W-1:0] NegWinPos  = POS_W'(-WIN_POS);

  state_e           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic             go_q, go_d;
  logic             lpoint_q, lpoint_d;
  logic             rpoint_q, rpoint_d;
  logic             foul_q, foul_d;
  logic             over_q, over_d;
  logic             winner_q, winner_d;

  logic [3:0]       rnd;
  logic             lOnly, rOnly, bothPush;
  logic [POS_W-1:0] posInc, posDec;
  logic             hitRight, hitLeft;
  logic [7:0]       reloadVal;
  logic             loadCnt;

  tug_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .rnd_o (rnd)
  );

  // Push decoding, candidate positions and win-line detection
  always_comb begin
    lOnly     = lpush & ~rpush;
    rOnly     = rpush & ~lpush;
    bothPush  = lpush & rpush;
    posInc    = pos_q + POS_W'(1);
    posDec    = pos_q - POS_W'(1);
    hitRight  = (posInc == WinPos);
    hitLeft   = (posDec == NegWinPos);
    reloadVal = DelayBase8 + {4'b0000, rnd};
  end

  // State and registered outputs; reset discards any round in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      pos_q    <= '0;
      go_q     <= 1'b0;
      lpoint_q <= 1'b0;
      rpoint_q <= 1'b0;
      foul_q   <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pos_q    <= pos_d;
      go_q     <= go_d;
      lpoint_q <= lpoint_d;
      rpoint_q <= rpoint_d;
      foul_q   <= foul_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  // Next state: pushes in WAIT are fouls and outrank the counter reaching zero
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = WAIT;
      end
      WAIT: begin
        if (lOnly)            state_d = hitRight ? DONE : WAIT;
        else if (rOnly)       state_d = hitLeft ? DONE : WAIT;
        else if (bothPush)    state_d = WAIT;
        else if (cnt_q == 8'd0) state_d = ARMED;
      end
      ARMED: begin
        if (lOnly)         state_d = hitLeft ? DONE : WAIT;
        else if (rOnly)    state_d = hitRight ? DONE : WAIT;
        else if (bothPush) state_d = WAIT;
      end
      DONE: begin
        if (start) state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next outputs: counter reloads on every entry into WAIT and on every foul
  always_comb begin
    loadCnt  = (state_d == WAIT) && ((state_q != WAIT) || lpush || rpush);
    cnt_d    = cnt_q;
    pos_d    = pos_q;
    go_d     = (state_d == ARMED);
    lpoint_d = 1'b0;
    rpoint_d = 1'b0;
    foul_d   = 1'b0;
    over_d   = over_q;
    winner_d = winner_q;

    if (loadCnt) begin
      cnt_d = reloadVal;
    end else if ((state_q == WAIT) && tick && (cnt_q != 8'd0)) begin
      cnt_d = cnt_q - 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) pos_d = '0;
      end
      WAIT: begin
        if (lOnly) begin
          foul_d   = 1'b1;
          rpoint_d = 1'b1;
          pos_d    = posInc;
          if (hitRight) begin
            over_d   = 1'b1;
            winner_d = 1'b1;
          end
        end else if (rOnly) begin
          foul_d   = 1'b1;
          lpoint_d = 1'b1;
          pos_d    = posDec;
          if (hitLeft) begin
            over_d   = 1'b1;
            winner_d = 1'b0;
          end
        end else if (bothPush) begin
          foul_d = 1'b1;
        end
      end
      ARMED: begin
        if (lOnly) begin
          lpoint_d = 1'b1;
          pos_d    = posDec;
          if (hitLeft) begin
            over_d   = 1'b1;
            winner_d = 1'b0;
          end
        end else if (rOnly) begin
          rpoint_d = 1'b1;
          pos_d    = posInc;
          if (hitRight) begin
            over_d   = 1'b1;
            winner_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (start) begin
          pos_d    = '0;
          over_d   = 1'b0;
          winner_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign go     = go_q;
  assign pos    = pos_q;
  assign lpoint = lpoint_q;
  assign rpoint = rpoint_q;
  assign foul   = foul_q;
  assign over   = over_q;
  assign winner = winner_q;

endmodule

// File: tb/tb_tug_referee.sv
// Directed bench for the tug-of-war round controller (DELAY_BASE=2, WIN_POS=4, tick every cycle).
module tb_tug_referee;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start;
  logic       lpush;
  logic       rpush;
  logic       go;
  logic [3:0] pos;
  logic       lpoint;
  logic       rpoint;
  logic       foul;
  logic       over;
  logic       winner;

  int errors = 0;
  int checks = 0;
  int expN;

  logic [7:0] modelLfsr;

  tug_referee #(
    .DELAY_BASE (2),
    .WIN_POS    (4),
    .LFSR_SEED  (8'hA5)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .tick   (tick),
    .start  (start),
    .lpush  (lpush),
    .rpush  (rpush),
    .go     (go),
    .pos    (pos),
    .lpoint (lpoint),
    .rpoint (rpoint),
    .foul   (foul),
    .over   (over),
    .winner (winner)
  );

  // 10-unit clock
  always #5 clk = ~clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, seeded by reset, stepping every clock
  always @(posedge clk or negedge rst) begin
    if (!rst) modelLfsr <= 8'hA5;
    else      modelLfsr <= {modelLfsr[6:0], modelLfsr[7] ^ modelLfsr[5] ^ modelLfsr[4] ^ modelLfsr[3]};
  end

  // Delay the referee will load if the counter is loaded at the next edge
  function automatic int delayNow();
    return 2 + int'(modelLfsr[3:0]);
  endfunction

  // Count one comparison and report it if it disagrees
  task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Compare every output against expected values
  task automatic checkState(input string tag, input logic eGo, input logic [3:0] ePos,
                            input logic eLp, input logic eRp, input logic eFoul,
                            input logic eOver, input logic eWin);
    checkOutput({tag, "_go"},     8'(go),     8'(eGo));
    checkOutput({tag, "_pos"},    8'(pos),    8'(ePos));
    checkOutput({tag, "_lpoint"}, 8'(lpoint), 8'(eLp));
    checkOutput({tag, "_rpoint"}, 8'(rpoint), 8'(eRp));
    checkOutput({tag, "_foul"},   8'(foul),   8'(eFoul));
    checkOutput({tag, "_over"},   8'(over),   8'(eOver));
    checkOutput({tag, "_winner"}, 8'(winner), 8'(eWin));
  endtask

  // Drive one cycle of inputs, then look just after the edge that consumed them
  task automatic applyStimulus(input logic s, input logic l, input logic r);
    start = s;
    lpush = l;
    rpush = r;
    @(posedge clk);
    #1;
    start = 1'b0;
    lpush = 1'b0;
    rpush = 1'b0;
  endtask

  // Idle until go rises (bounded) and check how many edges it took
  task automatic waitGo(input int expCycles, input string tag);
    int n;
    n = 0;
    while (go !== 1'b1 && n < 60) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      n++;
    end
    checkOutput({tag, "_delay"}, 8'(n), 8'(expCycles));
  endtask

  // Release reset between edges and settle one clock
  task automatic releaseReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b0;
    tick  = 1'b1;
    start = 1'b0;
    lpush = 1'b0;
    rpush = 1'b0;
    #12;
    checkState("reset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    releaseReset();

    // First game: start, then no pushes until go
    expN = delayNow();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("start_go", 8'(go), 8'h0);
    waitGo(expN + 1, "first");
    checkOutput("first_pos", 8'(pos), 8'h0);
    checkOutput("first_over", 8'(over), 8'h0);

    // Left scores four times and wins
    for (int i = 1; i <= 4; i++) begin
      expN = delayNow();
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkState($sformatf("lpt%0d", i), 1'b0, 4'(-i), 1'b1, 1'b0, 1'b0, (i == 4), 1'b0);
      if (i < 4) waitGo(expN + 1, $sformatf("lpt%0d", i));
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("ldone_hold", 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("ldone_lpush", 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("ldone_rpush", 1'b0, 4'hC, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Restart from DONE, then a right false start
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("restart", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("rfoul", 1'b0, 4'hF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Double false start: foul only
    expN = delayNow();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkState("dfoul", 1'b0, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    waitGo(expN + 1, "dfoul");

    // Tie while armed: no point, back to WAIT
    expN = delayNow();
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkState("tie", 1'b0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    waitGo(expN + 1, "tie");

    // Right scores four times: -1 -> +3
    for (int i = 0; i <= 3; i++) begin
      expN = delayNow();
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkState($sformatf("rpt%0d", i), 1'b0, 4'(i), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      waitGo(expN + 1, $sformatf("rpt%0d", i));
    end
    checkOutput("armed_pos3", 8'(pos), 8'h3);

    // Reset while armed at +3 clears without a clock edge
    rst = 1'b0;
    #2;
    checkState("midreset", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    releaseReset();
    expN = delayNow();
    checkOutput("reseed_lfsr", modelLfsr, dut.u_lfsr.lfsr_q);
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitGo(expN + 1, "reseed");

    // Right wins from zero
    for (int i = 1; i <= 4; i++) begin
      expN = delayNow();
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkState($sformatf("rwin%0d", i), 1'b0, 4'(i), 1'b0, 1'b1, 1'b0, (i == 4), (i == 4));
      if (i < 4) waitGo(expN + 1, $sformatf("rwin%0d", i));
    end

    // Restart from DONE with winner=1, push exactly in the counter-zero cycle
    expN = delayNow();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkState("restart2", 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < expN; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("zero_cycle_go", 8'(go), 8'h0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("zero_foul", 1'b0, 4'h1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkState("zero_after", 1'b0, 4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
